control_sequencer: RTL

Microcoded control unit for the 8-bit machine. Steps through fetch and execute micro-steps (T-states) and decodes the instruction register's upper-nibble opcode plus the carry and zero flags. Drives every load, output-enable and count strobe on the shared bus, including `load_ir` and `output_enable_ir` of the instruction register. Instructions have variable length; the step counter returns to T0 after each instruction's last micro-step.

---
 rtl/control_pkg.sv | 61 ++++++
 rtl/microcode_decoder.sv | 90 +++++++++
 rtl/control_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared constants for the microcoded control unit: opcodes, T-states, control-word layout.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package control_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_e;

    localparam int CW_W             = 15;
    localparam int CW_PC_OUT        = 14;
    localparam int CW_PC_ENABLE     = 13;
    localparam int CW_PC_LOAD       = 12;
    localparam int CW_MAR_LOAD      = 11;
    localparam int CW_RAM_OUT       = 10;
    localparam int CW_RAM_LOAD      = 9;
    localparam int CW_LOAD_IR       = 8;
    localparam int CW_OE_IR         = 7;
    localparam int CW_A_LOAD        = 6;
    localparam int CW_A_OUT         = 5;
    localparam int CW_B_LOAD        = 4;
    localparam int CW_ALU_OUT       = 3;
    localparam int CW_ALU_SUB       = 2;
    localparam int CW_FLAGS_LOAD    = 1;
    localparam int CW_OUT_LOAD      = 0;

    localparam logic [2:0] LAST_SHORT = T2;
    localparam logic [2:0] LAST_LDA   = T3;
    localparam logic [2:0] LAST_STA   = T3;
    localparam logic [2:0] LAST_ADD   = T4;
    localparam logic [2:0] LAST_SUB   = T4;

    function automatic logic [2:0] last_step_of(input logic [3:0] op);
        case (op)
            OP_LDA:  return LAST_LDA;
            OP_STA:  return LAST_STA;
            OP_ADD:  return LAST_ADD;
            OP_SUB:  return LAST_SUB;
            default: return LAST_SHORT;
        endcase
    endfunction

endpackage

// File: rtl/microcode_decoder.sv
// Maps {step, opcode, carry, zero} to the control word and an end-of-instruction flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
module microcode_decoder
    import control_pkg::*;
(
    input  logic [2:0]      step,
    input  logic [3:0]      opcode,
    input  logic            carry,
    input  logic            zero,
    output logic [CW_W-1:0] cw,
    output logic            last_step
);

    always_comb begin
        cw        = '0;
        last_step = 1'b0;
        case (step)
            T0: begin
                cw[CW_PC_OUT]   = 1'b1;
                cw[CW_MAR_LOAD] = 1'b1;
            end
            T1: begin
                cw[CW_RAM_OUT]   = 1'b1;
                cw[CW_LOAD_IR]   = 1'b1;
                cw[CW_PC_ENABLE] = 1'b1;
            end
            T2: begin
                last_step = (step >= last_step_of(opcode));
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw[CW_OE_IR]    = 1'b1;
                        cw[CW_MAR_LOAD] = 1'b1;
                    end
                    OP_LDI: begin
                        cw[CW_OE_IR]  = 1'b1;
                        cw[CW_A_LOAD] = 1'b1;
                    end
                    OP_JMP: begin
                        cw[CW_OE_IR]   = 1'b1;
                        cw[CW_PC_LOAD] = 1'b1;
                    end
                    OP_JC: begin
                        cw[CW_OE_IR]   = 1'b1;
                        cw[CW_PC_LOAD] = carry;
                    end
                    OP_JZ: begin
                        cw[CW_OE_IR]   = 1'b1;
                        cw[CW_PC_LOAD] = zero;
                    end
                    OP_OUT: begin
                        cw[CW_A_OUT]    = 1'b1;
                        cw[CW_OUT_LOAD] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T3: begin
                last_step = (step >= last_step_of(opcode));
                case (opcode)
                    OP_LDA: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_A_LOAD]  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_B_LOAD]  = 1'b1;
                    end
                    OP_STA: begin
                        cw[CW_A_OUT]    = 1'b1;
                        cw[CW_RAM_LOAD] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                last_step = 1'b1;
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    cw[CW_ALU_OUT]    = 1'b1;
                    cw[CW_A_LOAD]     = 1'b1;
                    cw[CW_FLAGS_LOAD] = 1'b1;
                    cw[CW_ALU_SUB]    = (opcode == OP_SUB);
                end
            end
            // Unused step encodings emit nothing and send the counter home.
            default: last_step = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// T-state sequencer and halt latch driving all bus strobes from the microcode decoder.
// Latency: strobes are combinational from the registered step; state advances once per clk.
// Backpressure: none; clear and halted force all strobes low.
module control_sequencer
    import control_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           clear,
    input  logic [N/2-1:0] opcode,
    input  logic           carry_flag,
    input  logic           zero_flag,
    output logic           pc_out,
    output logic           pc_enable,
    output logic           pc_load,
    output logic           mar_load,
    output logic           ram_out,
    output logic           ram_load,
    output logic           load_ir,
    output logic           output_enable_ir,
    output logic           a_load,
    output logic           a_out,
    output logic           b_load,
    output logic           alu_out,
    output logic           alu_sub,
    output logic           flags_load,
    output logic           out_load,
    output logic           halted,
    output logic [2:0]     step
);

    logic [2:0]      step_q;
    logic            halted_q;
    logic [3:0]      dec_opcode;
    logic [CW_W-1:0] cw;
    logic [CW_W-1:0] cw_gated;
    logic            last_step;
    logic            halt_now;

    // Only the 8-bit machine has a defined instruction set; other widths run NOPs.
    generate
        if (N == 8) begin : g_dec8
            assign dec_opcode = opcode;
        end else begin : g_decnop
            assign dec_opcode = OP_NOP;
        end
    endgenerate

    microcode_decoder u_decoder (
        .step      (step_q),
        .opcode    (dec_opcode),
        .carry     (carry_flag),
        .zero      (zero_flag),
        .cw        (cw),
        .last_step (last_step)
    );

    assign halt_now = (step_q == T2) && (dec_opcode == OP_HLT);

    always_ff @(posedge clk) begin
        if (clear) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else if (halted_q) begin
            step_q   <= step_q;
        end else if (halt_now) begin
            // Counter parks on T2 so the display shows where HLT stopped.
            halted_q <= 1'b1;
        end else if (last_step) begin
            step_q   <= T0;
        end else begin
            step_q   <= step_q + 3'd1;
        end
    end

    assign cw_gated = (clear || halted_q) ? '0 : cw;

    assign pc_out           = cw_gated[CW_PC_OUT];
    assign pc_enable        = cw_gated[CW_PC_ENABLE];
    assign pc_load          = cw_gated[CW_PC_LOAD];
    assign mar_load         = cw_gated[CW_MAR_LOAD];
    assign ram_out          = cw_gated[CW_RAM_OUT];
    assign ram_load         = cw_gated[CW_RAM_LOAD];
    assign load_ir          = cw_gated[CW_LOAD_IR];
    assign output_enable_ir = cw_gated[CW_OE_IR];
    assign a_load           = cw_gated[CW_A_LOAD];
    assign a_out            = cw_gated[CW_A_OUT];
    assign b_load           = cw_gated[CW_B_LOAD];
    assign alu_out          = cw_gated[CW_ALU_OUT];
    assign alu_sub          = cw_gated[CW_ALU_SUB];
    assign flags_load       = cw_gated[CW_FLAGS_LOAD];
    assign out_load         = cw_gated[CW_OUT_LOAD];
    assign halted           = halted_q;
    assign step             = step_q;

endmodule
